id_decode_stage: RTL and testbench
==================================

Name: id_decode_stage

Overview:
- Instruction-decode pipeline stage that produces the command set consumed by the execute-stage ALU.
- Command set: 4-bit funct code, sv, ls_w_mode, register addresses, immediate, control flags.
- Accepts 32-bit instructions from fetch over a valid/ready handshake and holds one registered output slot toward execute.
- Enforces a one-bubble load-use interlock and supports a flush.

Parameters:
- NONE_REQUIRED, -, block has no parameters; all widths are fixed at 32-bit datapath and 5-bit register addresses.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_instr  in  32  instruction word
- flush  in  1  discard the held output and refuse input this cycle
- out_valid  out  1  decoded command valid
- out_ready  in  1  execute accepts command
- out_funct  out  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SRLI, 7 SLLI, 8 ROTRI, 9 LSW, 10 SLT, 11 SUBRI, 12 MUL
- out_sv  out  2  scaled-index shift, register-form load/store
- out_ls_w_mode  out  1  1 = register-offset load/store (shift by sv), 0 = immediate form (shift by 2)
- out_rs1  out  5  source register a, instr[19:15]
- out_rs2  out  5  source register b, instr[14:10]
- out_rd  out  5  destination/store-data register, instr[24:20]
- out_imm  out  32  extended immediate
- out_src2_imm  out  1  ALU source2 is out_imm (else rs2)
- out_wb_en  out  1  writes rd
- out_mem_rd  out  1  load word
- out_mem_wr  out  1  store word
- out_illegal  out  1  unrecognised encoding

Behaviour:
- Reset: out_valid=0; all other outputs 0 (funct=NOP).
- Reset mid-transfer discards the held command. in_ready=0 while rst=1.
- Decode, when instr[31]=0, on opcode = instr[30:25]:
  - 100000 ALU_1, sub = instr[4:0]. Register forms (src2_imm=0, wb_en=1): 00000 ADD, 00001 SUB, 00010 AND, 00011 XOR, 00100 OR, 00110 SLT. Shift forms (src2_imm=1, imm = zero-extended instr[14:10], wb_en=1): 01000 SLLI, 01001 SRLI, 01011 ROTRI.
  - 100001 ALU_2 with instr[5:0]=100100: MUL, register form, wb_en=1.
  - 101000 ADDI and 101001 SUBRI: imm = sign-extended instr[14:0], src2_imm=1, wb_en=1.
  - 101010 ANDI, 101011 XORI, 101100 ORI: imm = zero-extended instr[14:0], src2_imm=1, wb_en=1.
  - 000010 LWI: LSW, ls_w_mode=0, imm = sign-extended instr[14:0], src2_imm=1, mem_rd=1, wb_en=1.
  - 001010 SWI: same as LWI but mem_wr=1, wb_en=0.
  - 011100 MEM with instr[7:0]=00000010 (LW) or 00001010 (SW): LSW, ls_w_mode=1, sv = instr[9:8], src2_imm=0; flags as for LWI/SWI.
- Any other encoding, or instr[31]=1: funct=NOP, illegal=1, wb_en=mem_rd=mem_wr=0. It is still delivered with out_valid=1.
- srli r0,r0,0 (0x40000009) decodes as SRLI, not as illegal.
- Output slot is free when out_valid=0 or out_ready=1.
- hazard = out_valid & out_mem_rd & (rd_out == rs1_in | (rd_out == rs2_in & instruction reads rs2)). "Instruction reads rs2" covers register-form ALU ops, MUL, and register LW/SW. Register 0 is not exempt.
- Store data register: in_instr[24:20] of an incoming store counts as a source for the hazard compare.
- in_ready = slot free & ~hazard & ~flush & ~rst.
- On in_valid & in_ready: output register loads the decode of in_instr; out_valid=1 next cycle. Latency is 1 cycle.
- Slot free with no transfer: out_valid<=0. Slot not free: all outputs hold stable.
- Hazard spacing: a dependent instruction is accepted no earlier than the cycle after the load leaves the slot. With out_ready held high this gives exactly one bubble cycle (out_valid=0).
- flush=1: out_valid<=0 next cycle regardless of out_ready; no input accepted; flush overrides a simultaneous transfer.
- Simultaneous out_ready and in_valid on a full slot: old command leaves and new one loads in the same edge; no bubble.

Test Plan:
- Reset then ADD r3,r1,r2 (0x40308800) with out_ready=1 -> next cycle out_valid=1, funct=1, rd=3, rs1=1, rs2=2, src2_imm=0, wb_en=1.
- ADDI r5,r4,-1 (0x50527FFF) -> funct=1, imm=0xFFFFFFFF, src2_imm=1; SUBRI with the same immediate -> funct=11.
- LW r6,[r1+(r2<<3)] (0x38608B02) -> funct=9, ls_w_mode=1, sv=3, mem_rd=1; LWI variant -> ls_w_mode=0.
- LWI r7 then ADD r8,r7,r1 back-to-back, out_ready=1 -> in_ready low for one cycle, exactly one out_valid=0 bubble, ADD follows.
- out_ready=0 for 4 cycles with command held -> outputs unchanged, in_ready=0. out_ready=1 with in_valid=1 -> new command next cycle, no bubble.
- Unknown opcode 111111 -> illegal=1, funct=0, wb_en=0. flush asserted with a command held -> out_valid=0 next cycle. rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/id_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for the decode stage.
interface id_decode_stage_if;
  // Fetch side
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  // Execute side
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_funct;
  logic [1:0]  out_sv;
  logic        out_ls_w_mode;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_src2_imm;
  logic        out_wb_en;
  logic        out_mem_rd;
  logic        out_mem_wr;
  logic        out_illegal;

  // The decode stage itself
  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_funct, out_sv, out_ls_w_mode, out_rs1, out_rs2, out_rd,
           out_imm, out_src2_imm, out_wb_en, out_mem_rd, out_mem_wr, out_illegal
  );

  // The surrounding pipeline (fetch + execute)
  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_funct, out_sv, out_ls_w_mode, out_rs1, out_rs2, out_rd,
           out_imm, out_src2_imm, out_wb_en, out_mem_rd, out_mem_wr, out_illegal
  );
endinterface

// File: rtl/id_decode_stage.sv
// Instruction decode stage: decodes a 32-bit instruction into an ALU command held in a
// single output slot, with a one-bubble load-use interlock and flush.
module id_decode_stage (
  input logic              clk,
  input logic              rst,
  id_decode_stage_if.slave bus
);

  localparam logic [3:0] FunctNop   = 4'd0;
  localparam logic [3:0] FunctAdd   = 4'd1;
  localparam logic [3:0] FunctSub   = 4'd2;
  localparam logic [3:0] FunctAnd   = 4'd3;
  localparam logic [3:0] FunctOr    = 4'd4;
  localparam logic [3:0] FunctXor   = 4'd5;
  localparam logic [3:0] FunctSrli  = 4'd6;
  localparam logic [3:0] FunctSlli  = 4'd7;
  localparam logic [3:0] FunctRotri = 4'd8;
  localparam logic [3:0] FunctLsw   = 4'd9;
  localparam logic [3:0] FunctSlt   = 4'd10;
  localparam logic [3:0] FunctSubri = 4'd11;
  localparam logic [3:0] FunctMul   = 4'd12;

  typedef struct packed {
    logic [3:0]  funct;
    logic [1:0]  sv;
    logic        ls_w_mode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        src2_imm;
    logic        wb_en;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;
  } cmd_t;

  cmd_t        dec, cmd_d, cmd_q;
  logic        valid_d, valid_q;
  logic        reads_rs2, is_store, hazard, slot_free, in_ready;
  logic [31:0] instr, imm_sext, imm_zext;
  logic [5:0]  opcode;

  assign instr    = bus.in_instr;
  assign opcode   = instr[30:25];
  assign imm_sext = {{17{instr[14]}}, instr[14:0]};
  assign imm_zext = {17'd0, instr[14:0]};

  // Decode the incoming word; anything unrecognised collapses to an illegal NOP.
  always_comb begin
    dec           = '0;
    dec.rd        = instr[24:20];
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[14:10];
    dec.illegal   = instr[31];
    reads_rs2     = 1'b0;
    if (!instr[31]) begin
      case (opcode)
        6'b100000: begin
          dec.wb_en = 1'b1;
          reads_rs2 = 1'b1;
          case (instr[4:0])
            5'b00000: dec.funct = FunctAdd;
            5'b00001: dec.funct = FunctSub;
            5'b00010: dec.funct = FunctAnd;
            5'b00011: dec.funct = FunctXor;
            5'b00100: dec.funct = FunctOr;
            5'b00110: dec.funct = FunctSlt;
            5'b01000, 5'b01001, 5'b01011: begin
              // Shift amount lives in the rs2 field; it is not a register read.
              reads_rs2    = 1'b0;
              dec.src2_imm = 1'b1;
              dec.imm      = {27'd0, instr[14:10]};
              dec.funct    = (instr[1:0] == 2'b00) ? FunctSlli :
                             (instr[1:0] == 2'b01) ? FunctSrli : FunctRotri;
            end
            default: dec.illegal = 1'b1;
          endcase
        end
        6'b100001: begin
          dec.funct   = FunctMul;
          dec.wb_en   = 1'b1;
          reads_rs2   = 1'b1;
          dec.illegal = (instr[5:0] != 6'b100100);
        end
        6'b101000, 6'b101001: begin
          dec.funct    = opcode[0] ? FunctSubri : FunctAdd;
          dec.imm      = imm_sext;
          dec.src2_imm = 1'b1;
          dec.wb_en    = 1'b1;
        end
        6'b101010, 6'b101011, 6'b101100: begin
          dec.funct    = (opcode == 6'b101010) ? FunctAnd :
                         (opcode == 6'b101011) ? FunctXor : FunctOr;
          dec.imm      = imm_zext;
          dec.src2_imm = 1'b1;
          dec.wb_en    = 1'b1;
        end
        6'b000010, 6'b001010: begin
          dec.funct    = FunctLsw;
          dec.imm      = imm_sext;
          dec.src2_imm = 1'b1;
          dec.mem_rd   = ~opcode[3];
          dec.mem_wr   = opcode[3];
          dec.wb_en    = ~opcode[3];
        end
        6'b011100: begin
          dec.funct     = FunctLsw;
          dec.ls_w_mode = 1'b1;
          dec.sv        = instr[9:8];
          reads_rs2     = 1'b1;
          dec.mem_rd    = (instr[7:0] == 8'h02);
          dec.mem_wr    = (instr[7:0] == 8'h0A);
          dec.wb_en     = dec.mem_rd;
          dec.illegal   = ~(dec.mem_rd | dec.mem_wr);
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    if (dec.illegal) begin
      dec.funct     = FunctNop;
      dec.sv        = 2'd0;
      dec.ls_w_mode = 1'b0;
      dec.imm       = '0;
      dec.src2_imm  = 1'b0;
      dec.wb_en     = 1'b0;
      dec.mem_rd    = 1'b0;
      dec.mem_wr    = 1'b0;
      reads_rs2     = 1'b0;
    end
  end

  // Load-use interlock: a store's data register (rd field) is also a source.
  assign is_store  = dec.mem_wr;
  assign hazard    = valid_q & cmd_q.mem_rd &
                     ((cmd_q.rd == dec.rs1) | (reads_rs2 & (cmd_q.rd == dec.rs2)) |
                      (is_store & (cmd_q.rd == dec.rd)));
  assign slot_free = ~valid_q | bus.out_ready;
  assign in_ready  = slot_free & ~hazard & ~bus.flush & ~rst;

  // Output slot next state: flush wins, then load, then drain.
  always_comb begin
    valid_d = valid_q;
    cmd_d   = cmd_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (bus.in_valid && in_ready) begin
      valid_d = 1'b1;
      cmd_d   = dec;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  // Output slot register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_funct     = cmd_q.funct;
  assign bus.out_sv        = cmd_q.sv;
  assign bus.out_ls_w_mode = cmd_q.ls_w_mode;
  assign bus.out_rs1       = cmd_q.rs1;
  assign bus.out_rs2       = cmd_q.rs2;
  assign bus.out_rd        = cmd_q.rd;
  assign bus.out_imm       = cmd_q.imm;
  assign bus.out_src2_imm  = cmd_q.src2_imm;
  assign bus.out_wb_en     = cmd_q.wb_en;
  assign bus.out_mem_rd    = cmd_q.mem_rd;
  assign bus.out_mem_wr    = cmd_q.mem_wr;
  assign bus.out_illegal   = cmd_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: decode table, hand-written pipeline sequences and random traffic
// checked against a transaction-level model of the output slot.
module tb_id_decode_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_decode_stage_if bus ();

  id_decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]  funct;
    logic [1:0]  sv;
    logic        lsw;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        s2i;
    logic        wb;
    logic        mrd;
    logic        mwr;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  funct;
    logic [31:0] imm;
    logic [1:0]  sv;
    logic        lsw, s2i, wb, mrd, mwr, ill;
  } vec_t;

  vec_t vec[32];
  int   nv = 0;

  int   n_checks = 0;
  int   n_fail   = 0;

  // Model of the single output slot
  logic m_valid;
  exp_t m_cmd;

  logic obs_ready, obs_valid;
  exp_t obs_cmd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [31:0] i, input logic [3:0] f, input logic [31:0] imm,
                         input logic [1:0] sv, input logic lsw, input logic s2i, input logic wb,
                         input logic mrd, input logic mwr, input logic ill);
    vec[nv].instr = i;   vec[nv].funct = f; vec[nv].imm = imm; vec[nv].sv = sv;
    vec[nv].lsw   = lsw; vec[nv].s2i   = s2i; vec[nv].wb = wb;
    vec[nv].mrd   = mrd; vec[nv].mwr   = mwr; vec[nv].ill = ill;
    nv++;
  endtask

  // Reference decode from the instruction-set tables.
  function automatic exp_t ref_decode(input logic [31:0] i);
    exp_t        e;
    logic [31:0] simm, zimm;
    logic        ok;
    e    = '0;
    zimm = 32'(i[14:0]);
    simm = i[14] ? (zimm - 32'd32768) : zimm;
    ok   = 1'b0;
    e.rd = i[24:20]; e.rs1 = i[19:15]; e.rs2 = i[14:10];
    if (i[31] == 1'b0) begin
      case (i[30:25])
        6'd32: begin
          ok = 1'b1; e.wb = 1'b1;
          case (i[4:0])
            5'd0:  e.funct = 4'd1;
            5'd1:  e.funct = 4'd2;
            5'd2:  e.funct = 4'd3;
            5'd3:  e.funct = 4'd5;
            5'd4:  e.funct = 4'd4;
            5'd6:  e.funct = 4'd10;
            5'd8:  begin e.funct = 4'd7; e.s2i = 1'b1; e.imm = 32'(i[14:10]); end
            5'd9:  begin e.funct = 4'd6; e.s2i = 1'b1; e.imm = 32'(i[14:10]); end
            5'd11: begin e.funct = 4'd8; e.s2i = 1'b1; e.imm = 32'(i[14:10]); end
            default: ok = 1'b0;
          endcase
        end
        6'd33: begin ok = (i[5:0] == 6'd36); e.funct = 4'd12; e.wb = 1'b1; end
        6'd40: begin ok = 1'b1; e.funct = 4'd1;  e.imm = simm; e.s2i = 1'b1; e.wb = 1'b1; end
        6'd41: begin ok = 1'b1; e.funct = 4'd11; e.imm = simm; e.s2i = 1'b1; e.wb = 1'b1; end
        6'd42: begin ok = 1'b1; e.funct = 4'd3;  e.imm = zimm; e.s2i = 1'b1; e.wb = 1'b1; end
        6'd43: begin ok = 1'b1; e.funct = 4'd5;  e.imm = zimm; e.s2i = 1'b1; e.wb = 1'b1; end
        6'd44: begin ok = 1'b1; e.funct = 4'd4;  e.imm = zimm; e.s2i = 1'b1; e.wb = 1'b1; end
        6'd2:  begin ok = 1'b1; e.funct = 4'd9; e.imm = simm; e.s2i = 1'b1; e.mrd = 1'b1;
                     e.wb = 1'b1; end
        6'd10: begin ok = 1'b1; e.funct = 4'd9; e.imm = simm; e.s2i = 1'b1; e.mwr = 1'b1; end
        6'd28: begin
          e.funct = 4'd9; e.lsw = 1'b1; e.sv = i[9:8];
          if (i[7:0] == 8'd2)  begin ok = 1'b1; e.mrd = 1'b1; e.wb = 1'b1; end
          if (i[7:0] == 8'd10) begin ok = 1'b1; e.mwr = 1'b1; end
        end
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      e = '0;
      e.rd = i[24:20]; e.rs1 = i[19:15]; e.rs2 = i[14:10];
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Does instruction i read register r (rs1 always; rs2 for register forms; rd for stores)?
  function automatic logic reads_reg(input logic [31:0] i, input logic [4:0] r);
    exp_t e;
    e = ref_decode(i);
    return (i[19:15] == r) || (!e.ill && !e.s2i && i[14:10] == r) || (e.mwr && i[24:20] == r);
  endfunction

  function automatic exp_t dut_cmd();
    exp_t g;
    g.funct = bus.out_funct;   g.sv  = bus.out_sv;     g.lsw = bus.out_ls_w_mode;
    g.rs1   = bus.out_rs1;     g.rs2 = bus.out_rs2;    g.rd  = bus.out_rd;
    g.imm   = bus.out_imm;     g.s2i = bus.out_src2_imm; g.wb = bus.out_wb_en;
    g.mrd   = bus.out_mem_rd;  g.mwr = bus.out_mem_wr; g.ill = bus.out_illegal;
    return g;
  endfunction

  // One clock: drive at negedge, compare shortly after, advance the model on posedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl,
                      input logic r);
    logic exp_rdy;
    exp_t got;
    bus.in_valid = v; bus.in_instr = ins; bus.out_ready = ordy; bus.flush = fl; rst = r;
    #1;
    exp_rdy = !r && !fl && (!m_valid || ordy) && !(m_valid && m_cmd.mrd && reads_reg(ins, m_cmd.rd));
    got = dut_cmd();
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    check("out_cmd", 64'(got), 64'(m_cmd));
    obs_ready = bus.in_ready; obs_valid = bus.out_valid; obs_cmd = got;
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_cmd = '0;
    end else if (fl) begin
      m_valid = 1'b0;
    end else if (v && exp_rdy) begin
      m_valid = 1'b1; m_cmd = ref_decode(ins);
    end else if (!m_valid || ordy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  logic [31:0] hz_instr[6];
  logic        hz_stall[6];
  logic [3:0]  hz_funct[6];

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    m_valid = 1'b0; m_cmd = '0;

    add_vec(32'h40308800, 4'd1,  32'h0,        2'd0, 0, 0, 1, 0, 0, 0);
    add_vec(32'h40308801, 4'd2,  32'h0,        2'd0, 0, 0, 1, 0, 0, 0);
    add_vec(32'h40308802, 4'd3,  32'h0,        2'd0, 0, 0, 1, 0, 0, 0);
    add_vec(32'h40308803, 4'd5,  32'h0,        2'd0, 0, 0, 1, 0, 0, 0);
    add_vec(32'h40308804, 4'd4,  32'h0,        2'd0, 0, 0, 1, 0, 0, 0);
    add_vec(32'h40308806, 4'd10, 32'h0,        2'd0, 0, 0, 1, 0, 0, 0);
    add_vec(32'h40000009, 4'd6,  32'h0,        2'd0, 0, 1, 1, 0, 0, 0);
    add_vec(32'h40111408, 4'd7,  32'h5,        2'd0, 0, 1, 1, 0, 0, 0);
    add_vec(32'h4011140B, 4'd8,  32'h5,        2'd0, 0, 1, 1, 0, 0, 0);
    add_vec(32'h42308824, 4'd12, 32'h0,        2'd0, 0, 0, 1, 0, 0, 0);
    add_vec(32'h50527FFF, 4'd1,  32'hFFFFFFFF, 2'd0, 0, 1, 1, 0, 0, 0);
    add_vec(32'h50521234, 4'd1,  32'h00001234, 2'd0, 0, 1, 1, 0, 0, 0);
    add_vec(32'h52527FFF, 4'd11, 32'hFFFFFFFF, 2'd0, 0, 1, 1, 0, 0, 0);
    add_vec(32'h54114000, 4'd3,  32'h00004000, 2'd0, 0, 1, 1, 0, 0, 0);
    add_vec(32'h56114000, 4'd5,  32'h00004000, 2'd0, 0, 1, 1, 0, 0, 0);
    add_vec(32'h58114000, 4'd4,  32'h00004000, 2'd0, 0, 1, 1, 0, 0, 0);
    add_vec(32'h38608B02, 4'd9,  32'h0,        2'd3, 1, 0, 1, 1, 0, 0);
    add_vec(32'h38608B0A, 4'd9,  32'h0,        2'd3, 1, 0, 0, 0, 1, 0);
    add_vec(32'h04608010, 4'd9,  32'h10,       2'd0, 0, 1, 1, 1, 0, 0);
    add_vec(32'h0460FFFC, 4'd9,  32'hFFFFFFFC, 2'd0, 0, 1, 1, 1, 0, 0);
    add_vec(32'h14608010, 4'd9,  32'h10,       2'd0, 0, 1, 0, 0, 1, 0);
    add_vec(32'h7E308800, 4'd0,  32'h0,        2'd0, 0, 0, 0, 0, 0, 1);
    add_vec(32'hC0308800, 4'd0,  32'h0,        2'd0, 0, 0, 0, 0, 0, 1);
    add_vec(32'h38608B03, 4'd0,  32'h0,        2'd0, 0, 0, 0, 0, 0, 1);
    add_vec(32'h40308805, 4'd0,  32'h0,        2'd0, 0, 0, 0, 0, 0, 1);
    add_vec(32'h42308825, 4'd0,  32'h0,        2'd0, 0, 0, 0, 0, 0, 1);

    // Second instruction after LWI r7: does it depend on r7?
    hz_instr[0] = 32'h40838400; hz_stall[0] = 1'b1; hz_funct[0] = 4'd1;  // ADD r8,r7,r1
    hz_instr[1] = 32'h40809C00; hz_stall[1] = 1'b1; hz_funct[1] = 4'd1;  // ADD r8,r1,r7
    hz_instr[2] = 32'h14708000; hz_stall[2] = 1'b1; hz_funct[2] = 4'd9;  // SWI r7 store data
    hz_instr[3] = 32'h40809C08; hz_stall[3] = 1'b0; hz_funct[3] = 4'd7;  // SLLI r8,r1,7
    hz_instr[4] = 32'h50809C00; hz_stall[4] = 1'b0; hz_funct[4] = 4'd1;  // ADDI imm field = 7
    hz_instr[5] = 32'h38909C02; hz_stall[5] = 1'b1; hz_funct[5] = 4'd9;  // LW r9,[r1+r7]

    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held: nothing accepted, everything zero
    step(1'b1, 32'h40308800, 1'b1, 1'b0, 1'b1);
    check("rst_in_ready", 64'(obs_ready), 64'd0);
    check("rst_out_valid", 64'(obs_valid), 64'd0);
    check("rst_cmd", 64'(obs_cmd), 64'd0);

    // Decode table, one instruction at a time through an empty slot
    for (int k = 0; k < nv; k++) begin
      step(1'b1, vec[k].instr, 1'b1, 1'b0, 1'b0);
      check($sformatf("vec%0d_accept", k), 64'(obs_ready), 64'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      check($sformatf("vec%0d_valid", k), 64'(obs_valid), 64'd1);
      check($sformatf("vec%0d_funct", k), 64'(obs_cmd.funct), 64'(vec[k].funct));
      check($sformatf("vec%0d_imm", k), 64'(obs_cmd.imm), 64'(vec[k].imm));
      check($sformatf("vec%0d_flags", k),
            64'({obs_cmd.sv, obs_cmd.lsw, obs_cmd.s2i, obs_cmd.wb, obs_cmd.mrd, obs_cmd.mwr,
                 obs_cmd.ill}),
            64'({vec[k].sv, vec[k].lsw, vec[k].s2i, vec[k].wb, vec[k].mrd, vec[k].mwr,
                 vec[k].ill}));
    end

    // Load-use interlock
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 32'h04708000, 1'b1, 1'b0, 1'b0);
      check($sformatf("hz%0d_lwi_accept", k), 64'(obs_ready), 64'd1);
      step(1'b1, hz_instr[k], 1'b1, 1'b0, 1'b0);
      check($sformatf("hz%0d_ready", k), 64'(obs_ready), 64'(!hz_stall[k]));
      check($sformatf("hz%0d_lwi_out", k), 64'(obs_cmd.funct), 64'd9);
      if (hz_stall[k]) begin
        step(1'b1, hz_instr[k], 1'b1, 1'b0, 1'b0);
        check($sformatf("hz%0d_bubble", k), 64'(obs_valid), 64'd0);
        check($sformatf("hz%0d_retry", k), 64'(obs_ready), 64'd1);
      end
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      check($sformatf("hz%0d_dep_valid", k), 64'(obs_valid), 64'd1);
      check($sformatf("hz%0d_dep_funct", k), 64'(obs_cmd.funct), 64'(hz_funct[k]));
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end

    // Backpressure: held command stays stable, then replaced with no bubble
    step(1'b1, 32'h40308800, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'h40308801, 1'b0, 1'b0, 1'b0);
      check("stall_ready", 64'(obs_ready), 64'd0);
      check("stall_held", 64'({obs_valid, obs_cmd.funct, obs_cmd.rd}), 64'({1'b1, 4'd1, 5'd3}));
    end
    step(1'b1, 32'h40308801, 1'b1, 1'b0, 1'b0);
    check("swap_ready", 64'(obs_ready), 64'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("swap_no_bubble", 64'({obs_valid, obs_cmd.funct}), 64'({1'b1, 4'd2}));

    // Flush with a held command, then flush against an empty slot
    step(1'b1, 32'h40308800, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h40308801, 1'b0, 1'b1, 1'b0);
    check("flush_ready", 64'(obs_ready), 64'd0);
    step(1'b1, 32'h40308801, 1'b1, 1'b0, 1'b0);
    check("flush_clears", 64'(obs_valid), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("after_flush", 64'({obs_valid, obs_cmd.funct}), 64'({1'b1, 4'd2}));
    step(1'b1, 32'h40308800, 1'b1, 1'b1, 1'b0);
    check("flush_refuses", 64'(obs_ready), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("flush_no_load", 64'(obs_valid), 64'd0);

    // Reset in the middle of a stall
    step(1'b1, 32'h50527FFF, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h40308801, 1'b0, 1'b0, 1'b1);
    check("rst_stall_ready", 64'(obs_ready), 64'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst_stall_clear", 64'({obs_valid, obs_cmd}), 64'd0);

    // Random traffic against the model; small register numbers provoke hazards
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ins;
      if ($urandom_range(0, 9) < 2) begin
        ins = $urandom;
      end else begin
        ins = vec[$urandom_range(0, nv - 1)].instr;
        ins[24:20] = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[14:10] = 5'($urandom_range(0, 3));
      end
      step(1'($urandom_range(0, 9) < 7), ins, 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
